// File: rtl/entrada_botones.sv
// Button front end: 2-flop sync + debounce per button, press -> one-entry event buffer (valid/ack).
// Press to evt_valid is DEBOUNCE_CYCLES+3 edges; an unacked pending event drops new presses into sticky overflow.
module entrada_botones #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       evt_ack,
  output logic [3:0] btn_level,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       s1_q, s2_q;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       stable_dly_q;
  logic [3:0]       rise;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic             cand_vld;
  logic [1:0]       cand_code;
  logic             lower_drop;

  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic             ovf_q, ovf_d;

  assign raw = {btnD, btnR, btnL, btnU};

  // A cycle where s2 matches stable restarts the count, so bounces never accumulate.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

  // Scan low priority first so any earlier hit means a lower press is lost.
  always_comb begin
    cand_vld   = 1'b0;
    cand_code  = 2'd0;
    lower_drop = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) begin
        if (cand_vld) lower_drop = 1'b1;
        cand_vld  = 1'b1;
        cand_code = 2'(i);
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    ovf_d       = ovf_q | lower_drop;
    if (cand_vld) begin
      if (!evt_valid_q || evt_ack) begin
        evt_valid_d = 1'b1;
        evt_code_d  = cand_code;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (evt_ack) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 2'd0;
      ovf_q        <= 1'b0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      ovf_q        <= ovf_d;
    end
  end

  assign btn_level = stable_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_entrada_botones.sv
// Bench for entrada_botones with DEBOUNCE_CYCLES = 4; expected event codes are queued at stimulus time.
module tb_entrada_botones;

  logic       clk = 1'b0;
  logic       btnC = 1'b1;
  logic       btnU = 1'b0, btnL = 1'b0, btnR = 1'b0, btnD = 1'b0;
  logic       evt_ack = 1'b0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       overflow;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] sb [$];
  logic [1:0] exp_code;

  entrada_botones #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .btnC(btnC), .btnU(btnU), .btnL(btnL), .btnR(btnR), .btnD(btnD),
    .evt_ack(evt_ack), .btn_level(btn_level), .evt_valid(evt_valid),
    .evt_code(evt_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every accepted event (valid & ack at an edge) must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!btnC && evt_valid === 1'b1 && evt_ack === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got code %0d, expected no event", evt_code);
      end else begin
        exp_code = sb.pop_front();
        if (evt_code !== exp_code) begin
          n_fail++;
          $display("FAIL sb_code: got %0d, expected %0d", evt_code, exp_code);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_one();
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
  endtask

  task automatic release_all();
    btnU = 1'b0; btnL = 1'b0; btnR = 1'b0; btnD = 1'b0;
    tick(10);
  endtask

  task automatic do_reset();
    btnC = 1'b1;
    tick(1);
    btnC = 1'b0;
  endtask

  task automatic test_reset();
    btnC = 1'b1;
    tick(2);
    btnC = 1'b0;
    n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b, expected 0000", btn_level); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", evt_valid); end
    n_checks++; if (evt_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d, expected 0", evt_code); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
  endtask

  task automatic test_clean_press();
    btnU = 1'b1;
    sb.push_back(2'd0);
    tick(5);
    n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL clean_level_e5: got %b, expected 0000", btn_level); end
    tick(1);
    n_checks++; if (btn_level !== 4'b0001) begin n_fail++; $display("FAIL clean_level_e6: got %b, expected 0001", btn_level); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL clean_valid_e6: got %b, expected 0", evt_valid); end
    tick(1);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin n_fail++; $display("FAIL clean_evt_e7: got v=%b c=%0d, expected v=1 c=0", evt_valid, evt_code); end
    tick(5);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin n_fail++; $display("FAIL clean_hold: got v=%b c=%0d, expected v=1 c=0", evt_valid, evt_code); end
    ack_one();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL clean_after_ack: got %b, expected 0", evt_valid); end
    release_all();
  endtask

  task automatic test_bounce();
    logic [7:0] seq;
    seq = 8'b1111_0111;
    sb.push_back(2'd1);
    for (int k = 0; k < 8; k++) begin
      btnL = seq[k];
      tick(1);
    end
    tick(1);
    n_checks++; if (btn_level[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_level_e9: got %b, expected 0", btn_level[1]); end
    tick(1);
    n_checks++; if (btn_level[1] !== 1'b1) begin n_fail++; $display("FAIL bounce_level_e10: got %b, expected 1", btn_level[1]); end
    tick(1);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd1) begin n_fail++; $display("FAIL bounce_evt_e11: got v=%b c=%0d, expected v=1 c=1", evt_valid, evt_code); end
    ack_one();
    tick(3);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_single: got %b, expected 0", evt_valid); end
    release_all();
  endtask

  task automatic test_simultaneous();
    btnR = 1'b1;
    btnD = 1'b1;
    sb.push_back(2'd2);
    tick(6);
    n_checks++; if (btn_level !== 4'b1100) begin n_fail++; $display("FAIL simul_level: got %b, expected 1100", btn_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf_e6: got %b, expected 0", overflow); end
    tick(1);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd2) begin n_fail++; $display("FAIL simul_evt: got v=%b c=%0d, expected v=1 c=2", evt_valid, evt_code); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL simul_ovf_e7: got %b, expected 1", overflow); end
    ack_one();
    release_all();
  endtask

  task automatic test_overflow();
    do_reset();
    btnU = 1'b1;
    sb.push_back(2'd0);
    tick(7);
    btnD = 1'b1;
    tick(7);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin n_fail++; $display("FAIL ovf_hold: got v=%b c=%0d, expected v=1 c=0", evt_valid, evt_code); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
    ack_one();
    release_all();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
  endtask

  task automatic test_ack_refill();
    do_reset();
    btnU = 1'b1;
    sb.push_back(2'd0);
    tick(7);
    btnD = 1'b1;
    sb.push_back(2'd3);
    tick(6);
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd3) begin n_fail++; $display("FAIL refill_evt: got v=%b c=%0d, expected v=1 c=3", evt_valid, evt_code); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL refill_ovf: got %b, expected 0", overflow); end
    ack_one();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL refill_drain: got %b, expected 0", evt_valid); end
    release_all();
  endtask

  task automatic test_release();
    btnU = 1'b1;
    sb.push_back(2'd0);
    tick(7);
    ack_one();
    tick(2);
    btnU = 1'b0;
    tick(5);
    n_checks++; if (btn_level[0] !== 1'b1) begin n_fail++; $display("FAIL release_e5: got %b, expected 1", btn_level[0]); end
    tick(1);
    n_checks++; if (btn_level[0] !== 1'b0) begin n_fail++; $display("FAIL release_e6: got %b, expected 0", btn_level[0]); end
    tick(3);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL release_noevt: got %b, expected 0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    btnL = 1'b1;
    tick(7);
    btnL = 1'b0;
    btnU = 1'b1;
    tick(3);
    btnC = 1'b1;
    tick(1);
    btnC = 1'b0;
    n_checks++; if (btn_level !== 4'b0000 || evt_valid !== 1'b0 || evt_code !== 2'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got lvl=%b v=%b c=%0d o=%b, expected all 0", btn_level, evt_valid, evt_code, overflow);
    end
    sb.push_back(2'd0);
    tick(5);
    n_checks++; if (btn_level[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_level_e5: got %b, expected 0", btn_level[0]); end
    tick(1);
    n_checks++; if (btn_level !== 4'b0001) begin n_fail++; $display("FAIL rstmid_level_e6: got %b, expected 0001", btn_level); end
    tick(1);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin n_fail++; $display("FAIL rstmid_evt: got v=%b c=%0d, expected v=1 c=0", evt_valid, evt_code); end
    ack_one();
    release_all();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_ack_refill();
    test_release();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d unconsumed, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
